fir_sample_feeder: RTL and testbench
====================================

# fir_sample_feeder

Upstream input stage for the 3-tap FIR filter. Accepts 3-bit signed samples from a producer over a valid/ready handshake and buffers them in a small synchronous FIFO. Releases exactly one sample per programmable sample period, driving the filter's `Xin`. On FIFO underflow it zero-stuffs or holds the last sample, and counts the event.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `DIV`, 4: sample period in `sys_clk` cycles; must be ≥2.
- `HOLD_LAST`, 0: underflow policy. 0 drives zero; 1 repeats the last sample.

Ports:
- `sys_clk`, in, 1: single clock; all logic is on the rising edge.
- `sys_rst`, in, 1: reset, synchronous and active-high.
- `enable`, in, 1: runs the sample-period counter.
- `s_valid`, in, 1: producer sample valid.
- `s_ready`, out, 1: feeder can accept a sample.
- `s_data`, in, 3: signed producer sample.
- `xin_out`, out, 3: signed sample to the filter; registered.
- `xin_strobe`, out, 1: one-cycle pulse marking a new `xin_out` period.
- `underflow`, out, 1: one-cycle pulse, coincident with `xin_strobe`, when the period had no data.
- `underflow_cnt`, out, 8: saturating underflow count.
- `level`, out, log2(DEPTH)+1: FIFO occupancy.

## Operation
- Push occurs when `s_valid && s_ready`.
  - `s_ready = !sys_rst && (level != DEPTH)`.
  - `s_ready` has no combinational path from the pop side. At full, `s_ready` is 0 even in a tick cycle.
  - `s_data` is stable-held by the producer while `s_valid && !s_ready`.
- Period counter `cnt` counts 0..DIV-1 while `enable` is 1.
  - A tick is `enable && cnt == DIV-1`.
  - `cnt` wraps to 0 after a tick.
  - When `enable` is 0, `cnt` is held (not cleared) and no tick occurs. The FIFO still accepts pushes.
- On a tick with `level != 0`: pop the head and register it into `xin_out`.
- On a tick with `level == 0`:
  - `xin_out` becomes 0 (`HOLD_LAST=0`) or keeps its value (`HOLD_LAST=1`).
  - `underflow` pulses.
  - `underflow_cnt` increments and saturates at 255.
- A push and a tick in the same cycle:
  - With the FIFO non-empty: both happen, and `level` is unchanged.
  - With the FIFO empty: there is no bypass. The tick is an underflow, and the pushed sample is the next pop.
- Sample width is fixed at 3 bits, two's complement, range −4..+3. Data passes bit-exact with no scaling or saturation.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. `level` is a separate counter (0..DEPTH).

## Timing
- Reset values: `xin_out`=0, `xin_strobe`=0, `underflow`=0, `underflow_cnt`=0, `level`=0, `cnt`=0, `s_ready`=0.
- `s_ready` becomes 1 in the first cycle after `sys_rst` deasserts.
- Reset mid-operation discards all FIFO contents and the period phase on the next edge. No pop or push completes in the reset cycle.
- Tick in cycle t: at the edge ending t, `xin_out` updates. `xin_strobe` (and `underflow` if applicable) is high during cycle t+1 only.
- `xin_out` is constant between strobes.
- With `enable` held high, strobes are exactly DIV cycles apart. The first strobe appears DIV cycles after `enable` rises from reset.
- Push-to-`xin_out` latency with an empty FIFO and a free-running counter: the sample is visible at the first tick strictly after the push cycle. Minimum is one cycle after the push edge.
- `level` updates on the edge following a push or pop.

## Structure
- Shared package `fir_pkg` holds:
  - `SAMPLE_W = 3`
  - `typedef logic signed [SAMPLE_W-1:0] sample_t`
  - coefficient constants for the filter family, so feeder and filter agree on sample width.
- Sub-module `sync_fifo` is parameterised by width and depth and provides push, pop, full, empty and level. It is the natural split for reuse by later stages.
- The feeder top holds the period counter, underflow logic and the output register.

## Test plan
- Reset then `enable`=1, DIV=4: push +1, −2, +3, −4 back-to-back, no further pushes.
  - `xin_out` = 1, −2, 3, −4, each after a `xin_strobe` spaced 4 cycles apart.
  - Then a strobe with `xin_out`=0, `underflow`=1, `underflow_cnt`=1.
- Fill to DEPTH=8 with `enable`=0.
  - `s_ready`=0 and `level`=8. A 9th `s_valid` is not accepted.
  - After `enable`=1, the first pop restores `s_ready`=1 in the next cycle.
- Empty FIFO, push +2 exactly in the tick cycle.
  - That strobe reports `underflow`=1.
  - The next strobe outputs `xin_out`=2.
- `HOLD_LAST=1`: push −3 and let it pop, then starve for 3 periods.
  - `xin_out` stays −3 across 3 underflow strobes.
  - `underflow_cnt`=3.
- Assert `sys_rst` for 1 cycle with `level`=5 mid-period.
  - Next cycle: `level`=0, `xin_out`=0, no strobe.
  - Strobes resume DIV cycles later.
- Starve for 300 periods: `underflow_cnt` saturates at 255.

Source files
------------

// File: rtl/fir_pkg.sv
// Types and constants shared by the 3-tap FIR family, so every stage
// agrees on sample width and coefficient values.
package fir_pkg;

   localparam int SAMPLE_W = 3;
   typedef logic signed [SAMPLE_W-1:0] sample_t;

   localparam int      NUM_TAPS = 3;
   localparam sample_t COEF_0   = 3'sd1;
   localparam sample_t COEF_1   = 3'sd2;
   localparam sample_t COEF_2   = 3'sd1;

   localparam int               UCNT_W   = 8;
   localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter. The head entry is
// always visible on rd_data_o; pop simply advances past it.
module sync_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full_o    = (level_q == (AW+1)'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   // NOTE: the storage array is deliberately not reset; level gates every
   // read, so stale entries are never observed and the array maps to plain RAM.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always_comb begin
      level_d = level_q;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/fir_sample_feeder.sv
// Input stage for the FIR: buffers producer samples and releases one per
// sample period on xin_out, zero-stuffing or holding on underflow.
module fir_sample_feeder
   import fir_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int DIV       = 4,
   parameter bit HOLD_LAST = 1'b0
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   enable,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  sample_t                s_data,
   output sample_t                xin_out,
   output logic                   xin_strobe,
   output logic                   underflow,
   output logic [UCNT_W-1:0]      underflow_cnt,
   output logic [$clog2(DEPTH):0] level
);

   localparam int CNT_W = $clog2(DIV);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   sample_t           xin_q, xin_d;
   logic              strobe_q, strobe_d;
   logic              uf_q, uf_d;
   logic [UCNT_W-1:0] ucnt_q, ucnt_d;

   logic    tick, push, pop;
   logic    fifo_full, fifo_empty;
   sample_t head;

   assign tick    = enable && (cnt_q == CNT_W'(DIV - 1));
   assign s_ready = !sys_rst && !fifo_full;
   assign push    = s_valid && s_ready;
   // An empty FIFO never pops, so a sample pushed in a tick cycle waits a period.
   assign pop     = tick && !fifo_empty;

   sync_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (sys_clk),
      .rst_i     (sys_rst),
      .push_i    (push),
      .wr_data_i (s_data),
      .pop_i     (pop),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (level)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      cnt_d    = cnt_q;
      xin_d    = xin_q;
      strobe_d = tick;
      uf_d     = 1'b0;
      ucnt_d   = ucnt_q;
      if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
         if (!fifo_empty) begin
            xin_d = head;
         end else begin
            uf_d = 1'b1;
            if (!HOLD_LAST) xin_d = '0;
            if (ucnt_q != UCNT_MAX) ucnt_d = ucnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_q    <= '0;
         xin_q    <= '0;
         strobe_q <= 1'b0;
         uf_q     <= 1'b0;
         ucnt_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         xin_q    <= xin_d;
         strobe_q <= strobe_d;
         uf_q     <= uf_d;
         ucnt_q   <= ucnt_d;
      end
   end

   assign xin_out       = xin_q;
   assign xin_strobe    = strobe_q;
   assign underflow     = uf_q;
   assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Drives two feeders (zero-stuff and hold-last) with the same stimulus and
// compares both against a queue-based reference of the sample-period rules.
module tb_fir_sample_feeder;
   import fir_pkg::*;

   localparam int DEPTH = 8;
   localparam int DIV   = 4;

   logic    clk = 1'b0;
   logic    rst, en, valid;
   sample_t data;

   logic        ready0, ready1, strobe0, strobe1, uf0, uf1;
   sample_t     xin0, xin1;
   logic [7:0]  ucnt0, ucnt1;
   logic [3:0]  level0, level1;

   always #5 clk = ~clk;

   fir_sample_feeder #(.DEPTH(DEPTH), .DIV(DIV), .HOLD_LAST(1'b0)) u_dut0 (
      .sys_clk(clk), .sys_rst(rst), .enable(en), .s_valid(valid), .s_ready(ready0),
      .s_data(data), .xin_out(xin0), .xin_strobe(strobe0), .underflow(uf0),
      .underflow_cnt(ucnt0), .level(level0));

   fir_sample_feeder #(.DEPTH(DEPTH), .DIV(DIV), .HOLD_LAST(1'b1)) u_dut1 (
      .sys_clk(clk), .sys_rst(rst), .enable(en), .s_valid(valid), .s_ready(ready1),
      .s_data(data), .xin_out(xin1), .xin_strobe(strobe1), .underflow(uf1),
      .underflow_cnt(ucnt1), .level(level1));

   int total = 0;
   int bad   = 0;

   // reference state
   int q[$];
   int phase = 0;
   int m_xin0 = 0, m_xin1 = 0, m_strobe = 0, m_uf = 0, m_ucnt = 0;
   bit stall = 1'b0;
   int strobe_log[$];

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: inputs are already set; check s_ready, advance the model,
   // take the edge, then check registered outputs on the falling edge.
   task automatic cycle();
      int  exp_ready;
      bit  do_push, tick;
      #1;
      exp_ready = (!rst && q.size() != DEPTH) ? 1 : 0;
      check("s_ready0", int'(ready0), exp_ready);
      check("s_ready1", int'(ready1), exp_ready);
      do_push = valid && (exp_ready == 1);
      stall   = valid && (exp_ready == 0);
      if (rst) begin
         q.delete();
         phase = 0; m_xin0 = 0; m_xin1 = 0; m_strobe = 0; m_uf = 0; m_ucnt = 0;
      end else begin
         tick = en && (phase == DIV - 1);
         if (en) phase = (phase + 1) % DIV;
         m_strobe = tick ? 1 : 0;
         m_uf = 0;
         if (tick) begin
            if (q.size() > 0) begin
               m_xin0 = q.pop_front();
               m_xin1 = m_xin0;
            end else begin
               m_uf = 1;
               m_xin0 = 0;
               if (m_ucnt < 255) m_ucnt++;
            end
         end
         if (do_push) q.push_back(int'(data));
      end
      @(posedge clk);
      @(negedge clk);
      check("xin0",   int'(xin0),    m_xin0);
      check("xin1",   int'(xin1),    m_xin1);
      check("strobe0", int'(strobe0), m_strobe);
      check("strobe1", int'(strobe1), m_strobe);
      check("uf0",    int'(uf0),     m_uf);
      check("uf1",    int'(uf1),     m_uf);
      check("ucnt0",  int'(ucnt0),   m_ucnt);
      check("ucnt1",  int'(ucnt1),   m_ucnt);
      check("level0", int'(level0),  q.size());
      check("level1", int'(level1),  q.size());
      if (strobe0) strobe_log.push_back(int'(xin0));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; valid = 1'b0;
      run(n);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int s1_exp[5] = '{1, -2, 3, -4, 0};
      int s1_in[4]  = '{1, -2, 3, -4};
      int guard;

      rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
      do_reset(2);

      // back-to-back pushes, then one starved period
      en = 1'b1;
      strobe_log.delete();
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; data = sample_t'(s1_in[i]);
         cycle();
      end
      valid = 1'b0;
      run(16);
      check("s1_strobes", strobe_log.size(), 5);
      for (int i = 0; i < 5 && i < strobe_log.size(); i++)
         check("s1_xin", strobe_log[i], s1_exp[i]);
      check("s1_uf", int'(uf0), 1);
      check("s1_ucnt", int'(ucnt0), 1);

      // fill with the counter stopped; 9th sample must stall
      en = 1'b0;
      for (int i = 0; i < 9; i++) begin
         valid = 1'b1;
         if (!stall) data = sample_t'($urandom);
         cycle();
      end
      check("s2_level", int'(level0), 8);
      check("s2_ready", int'(ready0), 0);
      en = 1'b1;
      guard = 0;
      while (q.size() == DEPTH && guard < 20) begin cycle(); guard++; end
      check("s2_pop_seen", (guard < 20) ? 1 : 0, 1);
      check("s2_ready_after_pop", int'(ready0), 1);
      cycle();
      valid = 1'b0;

      // drain, then push exactly in a tick cycle
      guard = 0;
      while ((q.size() != 0 || phase != DIV - 1) && guard < 200) begin cycle(); guard++; end
      check("s3_aligned", (guard < 200) ? 1 : 0, 1);
      valid = 1'b1; data = 3'sd2;
      cycle();
      valid = 1'b0;
      check("s3_uf", int'(uf0), 1);
      check("s3_strobe", int'(strobe0), 1);
      run(DIV);
      check("s3_strobe2", int'(strobe0), 1);
      check("s3_xin", int'(xin0), 2);

      // hold-last: pop -3 then starve three periods
      do_reset(1);
      en = 1'b1;
      valid = 1'b1; data = -3'sd3;
      cycle();
      valid = 1'b0;
      run(DIV - 1);
      check("s4_pop", int'(xin1), -3);
      for (int p = 0; p < 3; p++) begin
         run(DIV);
         check("s4_uf", int'(uf1), 1);
         check("s4_hold", int'(xin1), -3);
         check("s4_zero", int'(xin0), 0);
      end
      check("s4_ucnt", int'(ucnt1), 3);

      // reset mid-period with five samples queued
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1; data = sample_t'($urandom);
         cycle();
      end
      valid = 1'b0; en = 1'b1;
      run(2);
      check("s5_level_pre", int'(level0), 5);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("s5_level", int'(level0), 0);
      check("s5_xin", int'(xin0), 0);
      check("s5_strobe", int'(strobe0), 0);
      run(DIV);
      check("s5_resume", int'(strobe0), 1);

      // long starvation saturates the counter
      run(300 * DIV);
      check("s6_sat", int'(ucnt0), 255);
      check("s6_sat1", int'(ucnt1), 255);

      // random traffic with occasional resets and enable gaps
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst = 1'b1;
         end else begin
            rst = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) en = ~en;
         if (!stall) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = sample_t'($urandom);
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
